// File: rtl/int_pe_vec.sv
// int_pe_vec: multi-lane weight-stationary integer PE with double-buffered weights and saturating partial sums
// Ports: clk/rst (async, active-low); cfg_signed_in selects two's-complement math;
// fsm_out_select_in selects MAC (1) or bypass (0); w_load_in/w_in fill the shadow weights,
// w_swap_in promotes them to active; left_* activations pass right after one cycle;
// top_* partial sums pass down after two cycles as bottom_*; sat_out flags a clamped sum.
module int_pe_vec #(
  parameter int WORD_SIZE     = 4,
  parameter int LANES         = 2,
  parameter int ADD_BIT_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_signed_in,
  input  logic                         fsm_out_select_in,
  input  logic                         w_load_in,
  input  logic [LANES*WORD_SIZE-1:0]   w_in,
  input  logic                         w_swap_in,
  input  logic                         left_valid_in,
  input  logic [LANES*WORD_SIZE-1:0]   left_in,
  input  logic                         top_valid_in,
  input  logic [ADD_BIT_WIDTH-1:0]     top_in,
  output logic                         right_valid_out,
  output logic [LANES*WORD_SIZE-1:0]   right_out,
  output logic                         bottom_valid_out,
  output logic [ADD_BIT_WIDTH-1:0]     bottom_out,
  output logic                         sat_out
);
  localparam int LW = LANES * WORD_SIZE;
  localparam int PW = 2 * WORD_SIZE;
  localparam int AW = ADD_BIT_WIDTH;
  localparam int SW = AW + $clog2(LANES) + 2;
  logic [LW-1:0] shadow_w, active_w;
  logic v1, m1, s1;
  logic [AW-1:0] t1;
  logic [LANES-1:0][PW-1:0] p1, prod;
  logic fire1, ovf;
  logic [SW-1:0] sum;
  logic [AW-1:0] res;
  function automatic logic [PW-1:0] ext_op(input logic [WORD_SIZE-1:0] x, input logic s);
    return {{WORD_SIZE{s & x[WORD_SIZE-1]}}, x};
  endfunction
  assign fire1 = fsm_out_select_in ? (left_valid_in & top_valid_in) : top_valid_in;
  // Operands extended to full product width so the truncated product is exact in both modes
  always_comb begin
    prod = '0;
    for (int k = 0; k < LANES; k++)
      prod[k] = ext_op(left_in[k*WORD_SIZE +: WORD_SIZE], cfg_signed_in) * ext_op(active_w[k*WORD_SIZE +: WORD_SIZE], cfg_signed_in);
  end
  // Wide sum cannot overflow; clamping only inspects the bits above the output width
  always_comb begin
    sum = {{(SW-AW){s1 & t1[AW-1]}}, t1};
    for (int k = 0; k < LANES; k++)
      sum = sum + {{(SW-PW){s1 & p1[k][PW-1]}}, p1[k]};
    ovf = s1 ? ~(&sum[SW-1:AW-1] | ~|sum[SW-1:AW-1]) : |sum[SW-1:AW];
    res = !ovf ? sum[AW-1:0] : s1 ? {sum[SW-1], {(AW-1){~sum[SW-1]}}} : '1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_w         <= '0;
      active_w         <= '0;
      right_valid_out  <= 1'b0;
      right_out        <= '0;
      v1               <= 1'b0;
      m1               <= 1'b0;
      s1               <= 1'b0;
      t1               <= '0;
      p1               <= '0;
      bottom_valid_out <= 1'b0;
      bottom_out       <= '0;
      sat_out          <= 1'b0;
    end else begin
      if (w_load_in) shadow_w <= w_in;
      if (w_swap_in) active_w <= shadow_w;
      right_valid_out <= left_valid_in;
      if (left_valid_in) right_out <= left_in;
      v1 <= fire1;
      if (fire1) begin
        m1 <= fsm_out_select_in;
        s1 <= cfg_signed_in;
        t1 <= top_in;
        if (fsm_out_select_in) p1 <= prod;
      end
      bottom_valid_out <= v1;
      if (v1) begin
        bottom_out <= m1 ? res : t1;
        sat_out    <= m1 & ovf;
      end
    end
  end
endmodule

// File: tb/tb_int_pe_vec.sv
// tb_int_pe_vec: scoreboard bench for int_pe_vec
module tb_int_pe_vec;
  logic clk = 1'b0, rst = 1'b0;
  logic cfg_signed_in = 0, fsm_out_select_in = 0, w_load_in = 0, w_swap_in = 0;
  logic left_valid_in = 0, top_valid_in = 0;
  logic [7:0] w_in = 0, left_in = 0;
  logic [23:0] top_in = 0;
  logic right_valid_out, bottom_valid_out, sat_out;
  logic [7:0] right_out;
  logic [23:0] bottom_out;
  int checks = 0, failures = 0;
  logic [24:0] sbq[$];
  logic [7:0] sh = 0, act = 0;
  logic [23:0] held;
  int_pe_vec dut (
    .clk(clk), .rst(rst), .cfg_signed_in(cfg_signed_in), .fsm_out_select_in(fsm_out_select_in),
    .w_load_in(w_load_in), .w_in(w_in), .w_swap_in(w_swap_in),
    .left_valid_in(left_valid_in), .left_in(left_in), .top_valid_in(top_valid_in), .top_in(top_in),
    .right_valid_out(right_valid_out), .right_out(right_out),
    .bottom_valid_out(bottom_valid_out), .bottom_out(bottom_out), .sat_out(sat_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [24:0] model(input logic sg, input logic [7:0] l, input logic [7:0] w, input logic [23:0] t);
    longint acc, a, b;
    acc = longint'(t);
    if (sg && t[23]) acc -= 64'sd1 << 24;
    for (int k = 0; k < 2; k++) begin
      a = longint'(l[k*4 +: 4]);
      b = longint'(w[k*4 +: 4]);
      if (sg && a > 7) a -= 16;
      if (sg && b > 7) b -= 16;
      acc += a * b;
    end
    if (sg) begin
      if (acc > 64'sd8388607) return {1'b1, 24'h7FFFFF};
      if (acc < -64'sd8388608) return {1'b1, 24'h800000};
    end else if (acc > 64'sd16777215) return {1'b1, 24'hFFFFFF};
    return {1'b0, acc[23:0]};
  endfunction
  task automatic beat(input logic mode, input logic sg, input logic lv, input logic tv, input logic [7:0] l,
                      input logic [23:0] t, input logic ld = 0, input logic [7:0] w = 0, input logic sw = 0,
                      input logic use_k = 0, input logic [24:0] k = 0);
    fsm_out_select_in = mode; cfg_signed_in = sg; left_valid_in = lv; top_valid_in = tv;
    left_in = l; top_in = t; w_load_in = ld; w_in = w; w_swap_in = sw;
    if (mode ? (lv & tv) : tv) sbq.push_back(use_k ? k : mode ? model(sg, l, act, t) : {1'b0, t});
    if (sw) act = sh;
    if (ld) sh = w;
    @(negedge clk);
  endtask
  task automatic idle();
    beat(1, 0, 0, 0, 8'h00, 24'h0);
  endtask
  always @(negedge clk) begin
    if (rst && bottom_valid_out) begin
      check("sb_nonempty", 64'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        logic [24:0] e;
        e = sbq.pop_front();
        check("bottom_out", bottom_out, e[23:0]);
        check("sat_out", sat_out, e[24]);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    check("rst_bottom_valid", bottom_valid_out, 0);
    check("rst_bottom_out", bottom_out, 0);
    check("rst_right_valid", right_valid_out, 0);
    check("rst_sat", sat_out, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    beat(1, 1, 0, 0, 0, 0, 1, 8'h78);
    beat(1, 1, 0, 0, 0, 0, 0, 0, 1);
    beat(1, 1, 1, 1, 8'h88, 24'd100, 0, 0, 0, 1, {1'b0, 24'd108});
    beat(1, 0, 1, 1, 8'h88, 24'd0, 0, 0, 0, 1, {1'b0, 24'd120});
    beat(1, 1, 0, 0, 0, 0, 1, 8'h87);
    beat(1, 1, 0, 0, 0, 0, 0, 0, 1);
    beat(1, 1, 1, 1, 8'h87, 24'h7FFFF0, 0, 0, 0, 1, {1'b1, 24'h7FFFFF});
    beat(1, 1, 0, 0, 0, 0, 1, 8'h78);
    beat(1, 1, 0, 0, 0, 0, 0, 0, 1);
    beat(1, 1, 1, 1, 8'h87, 24'h800000, 0, 0, 0, 1, {1'b1, 24'h800000});
    beat(0, 1, 0, 1, 8'h00, 24'h123456, 0, 0, 0, 1, {1'b0, 24'h123456});
    repeat (3) idle();
    held = bottom_out;
    beat(1, 1, 1, 0, 8'hA5, 24'h000001);
    check("right_out_follow", right_out, 8'hA5);
    check("right_valid_set", right_valid_out, 1);
    beat(1, 1, 0, 0, 8'h5A, 24'h000002);
    check("right_out_hold", right_out, 8'hA5);
    check("right_valid_clr", right_valid_out, 0);
    check("no_top_valid", bottom_valid_out, 0);
    check("bottom_hold", bottom_out, held);
    beat(1, 1, 0, 0, 0, 0, 1, 8'h12);
    beat(1, 1, 0, 0, 0, 0, 0, 0, 1);
    beat(1, 1, 0, 0, 0, 0, 1, 8'h34);
    beat(1, 1, 1, 1, 8'h9B, 24'd5);
    beat(1, 1, 1, 1, 8'h9B, 24'd6, 1, 8'h56, 1);
    beat(1, 1, 1, 1, 8'h9B, 24'd7);
    beat(1, 0, 1, 1, 8'hC3, 24'd8);
    beat(1, 1, 1, 1, 8'h9B, 24'd9, 0, 0, 1);
    beat(1, 1, 1, 1, 8'h9B, 24'd10);
    for (int i = 0; i < 60; i++)
      beat($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           8'($urandom), (i % 5 == 0) ? 24'h7FFF00 + 24'($urandom_range(0, 255)) : 24'($urandom),
           1'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 10 && sbq.size() != 0; i++) idle();
    check("drain", sbq.size(), 0);
    beat(1, 1, 1, 1, 8'h77, 24'h7FFFF0);
    beat(1, 1, 1, 1, 8'h77, 24'h7FFFF0);
    #2;
    rst = 0;
    left_valid_in = 1; top_valid_in = 1; left_in = 8'($urandom); top_in = 24'($urandom);
    w_load_in = 1; w_swap_in = 1; w_in = 8'($urandom);
    #1;
    check("mid_rst_bottom_valid", bottom_valid_out, 0);
    check("mid_rst_bottom_out", bottom_out, 0);
    check("mid_rst_sat", sat_out, 0);
    check("mid_rst_right_valid", right_valid_out, 0);
    check("mid_rst_right_out", right_out, 0);
    sbq.delete();
    sh = 0; act = 0;
    @(negedge clk);
    check("rst_held_valid", bottom_valid_out, 0);
    rst = 1;
    beat(0, 0, 0, 1, 8'h00, 24'hABCDEF, 0, 0, 0, 1, {1'b0, 24'hABCDEF});
    check("lat_edge1", bottom_valid_out, 0);
    idle();
    check("lat_edge2", bottom_valid_out, 1);
    beat(1, 1, 1, 1, 8'h11, 24'd3, 0, 0, 0, 1, {1'b0, 24'd3});
    for (int i = 0; i < 10 && sbq.size() != 0; i++) idle();
    check("drain_final", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
